// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the SRAM channel arbiter: instruction codes,
// per-channel owner encoding and the per-requester FSM states.
package sram_arb_pkg;

    localparam int N_SRAM = 4;
    localparam int N_REQ  = 2;

    localparam logic [7:0] INST_NOP   = 8'd0;
    localparam logic [7:0] INST_WRITE = 8'd2;
    localparam logic [7:0] INST_READ  = 8'd3;

    typedef enum logic [1:0] {
        OWN_FREE      = 2'b00,
        OWN_REQ0      = 2'b01,
        OWN_REQ1      = 2'b10,
        OWN_RELEASING = 2'b11
    } owner_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OWN,
        ST_DRAIN,
        ST_RELEASE
    } req_state_e;

    function automatic owner_e owner_code(input int r);
        return (r == 0) ? OWN_REQ0 : OWN_REQ1;
    endfunction

endpackage

// File: rtl/sram_channel_port.sv
// One SRAM channel: forwards the owner's command bundle, routes read-side
// signals back to the owner only, and tracks whether a transfer is in flight.
module sram_channel_port
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  owner_e                        owner_i,
    input  logic [N_REQ-1:0][7:0]         r_inst_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  r_address_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  r_byte_length_i,
    input  logic [N_REQ-1:0]              r_write_in_i,
    output logic [N_REQ-1:0]              r_mem_out_o,
    output logic [N_REQ-1:0]              r_io_valid_o,
    output logic [N_REQ-1:0]              r_rw_done_o,
    output logic [7:0]                    inst_o,
    output logic [ADDR_W-1:0]             address_o,
    output logic [ADDR_W-1:0]             byte_length_o,
    output logic                          write_in_o,
    input  logic                          mem_out_i,
    input  logic                          io_valid_i,
    input  logic                          rw_done_i,
    output logic                          op_active_o,
    output logic [N_REQ-1:0]              illegal_o
);

    logic op_active_d, op_active_q;

    // Free and releasing channels match no requester, so they drive all zeros.
    always_comb begin
        inst_o        = INST_NOP;
        address_o     = '0;
        byte_length_o = '0;
        write_in_o    = 1'b0;
        r_mem_out_o   = '0;
        r_io_valid_o  = '0;
        r_rw_done_o   = '0;
        illegal_o     = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (owner_i == owner_code(r)) begin
                inst_o          = r_inst_i[r];
                address_o       = r_address_i[r];
                byte_length_o   = r_byte_length_i[r];
                write_in_o      = r_write_in_i[r];
                r_mem_out_o[r]  = mem_out_i;
                r_io_valid_o[r] = io_valid_i;
                r_rw_done_o[r]  = rw_done_i;
            end else if (r_inst_i[r] != INST_NOP) begin
                illegal_o[r] = 1'b1;
            end
        end
    end

    // Completion beats a same-cycle issue; a held inst re-arms on the next cycle.
    always_comb begin
        op_active_d = op_active_q;
        if (rw_done_i) begin
            op_active_d = 1'b0;
        end else if (inst_o != INST_NOP) begin
            op_active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_active_q <= 1'b0;
        end else begin
            op_active_q <= op_active_d;
        end
    end

    assign op_active_o = op_active_q;

endmodule

// File: rtl/sram_channel_arbiter.sv
// Shares four serial SRAM channels between two requesters with atomic mask
// grants, round-robin tie breaking and a drain-before-release handshake.
module sram_channel_arbiter #(
    parameter int N_SRAM = sram_arb_pkg::N_SRAM,
    parameter int N_REQ  = sram_arb_pkg::N_REQ,
    parameter int ADDR_W = 24
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [N_REQ-1:0]                        req_valid,
    input  logic [N_REQ-1:0][N_SRAM-1:0]            req_mask,
    input  logic [N_REQ-1:0]                        req_release,
    output logic [N_REQ-1:0]                        gnt,
    output logic [N_REQ-1:0]                        req_error,
    input  logic [N_REQ-1:0][N_SRAM-1:0][7:0]       r_inst,
    input  logic [N_REQ-1:0][N_SRAM-1:0][ADDR_W-1:0] r_address,
    input  logic [N_REQ-1:0][N_SRAM-1:0][ADDR_W-1:0] r_byte_length,
    input  logic [N_REQ-1:0][N_SRAM-1:0]            r_write_in,
    output logic [N_REQ-1:0][N_SRAM-1:0]            r_mem_out,
    output logic [N_REQ-1:0][N_SRAM-1:0]            r_io_valid,
    output logic [N_REQ-1:0][N_SRAM-1:0]            r_rw_done,
    output logic [N_SRAM-1:0][7:0]                  inst,
    output logic [N_SRAM-1:0][ADDR_W-1:0]           address,
    output logic [N_SRAM-1:0][ADDR_W-1:0]           byte_length,
    output logic [N_SRAM-1:0]                       write_in,
    input  logic [N_SRAM-1:0]                       mem_out,
    input  logic [N_SRAM-1:0]                       io_valid,
    input  logic [N_SRAM-1:0]                       rw_done,
    output logic [N_SRAM-1:0][1:0]                  channel_owner
);

    import sram_arb_pkg::*;

    req_state_e        state_q [N_REQ];
    logic [N_SRAM-1:0] mask_q  [N_REQ];
    owner_e            owner_q [N_SRAM];
    logic [N_REQ-1:0]  illegal [N_SRAM];
    logic [N_REQ-1:0]  gnt_q, err_q, err_d;
    logic [N_REQ-1:0]  grantable, grant, busy, bad_inst, leaving, to_drain;
    logic [N_SRAM-1:0] op_active;
    logic              rr_last_q, tie;

    for (genvar c = 0; c < N_SRAM; c++) begin : g_ch
        logic [N_REQ-1:0][7:0]        ch_inst;
        logic [N_REQ-1:0][ADDR_W-1:0] ch_addr, ch_len;
        logic [N_REQ-1:0]             ch_win, ch_mem, ch_iov, ch_done;

        for (genvar r = 0; r < N_REQ; r++) begin : g_req
            assign ch_inst[r]       = r_inst[r][c];
            assign ch_addr[r]       = r_address[r][c];
            assign ch_len[r]        = r_byte_length[r][c];
            assign ch_win[r]        = r_write_in[r][c];
            assign r_mem_out[r][c]  = ch_mem[r];
            assign r_io_valid[r][c] = ch_iov[r];
            assign r_rw_done[r][c]  = ch_done[r];
        end

        sram_channel_port #(.ADDR_W(ADDR_W)) u_port (
            .clk             (clk),
            .reset           (reset),
            .owner_i         (owner_q[c]),
            .r_inst_i        (ch_inst),
            .r_address_i     (ch_addr),
            .r_byte_length_i (ch_len),
            .r_write_in_i    (ch_win),
            .r_mem_out_o     (ch_mem),
            .r_io_valid_o    (ch_iov),
            .r_rw_done_o     (ch_done),
            .inst_o          (inst[c]),
            .address_o       (address[c]),
            .byte_length_o   (byte_length[c]),
            .write_in_o      (write_in[c]),
            .mem_out_i       (mem_out[c]),
            .io_valid_i      (io_valid[c]),
            .rw_done_i       (rw_done[c]),
            .op_active_o     (op_active[c]),
            .illegal_o       (illegal[c])
        );
    end

    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            grantable[r] = (state_q[r] == ST_WAIT);
            busy[r]      = |(mask_q[r] & op_active);
            bad_inst[r]  = 1'b0;
            for (int c = 0; c < N_SRAM; c++) begin
                if (mask_q[r][c] && owner_q[c] != OWN_FREE) grantable[r] = 1'b0;
                if (illegal[c][r]) bad_inst[r] = 1'b1;
            end
            to_drain[r] = (state_q[r] == ST_OWN) && req_release[r] && busy[r];
            leaving[r]  = ((state_q[r] == ST_OWN) && req_release[r] && !busy[r]) ||
                          ((state_q[r] == ST_DRAIN) && !busy[r]);
            err_d[r]    = bad_inst[r] ||
                          (req_release[r] && state_q[r] != ST_OWN) ||
                          (state_q[r] == ST_IDLE && req_valid[r] && req_mask[r] == '0);
        end
        // Overlapping claims ready together: the requester that did not win last time goes.
        tie   = grantable[0] && grantable[1] && (|(mask_q[0] & mask_q[1]));
        grant = grantable;
        if (tie) grant[rr_last_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N_REQ; r++) state_q[r] <= ST_IDLE;
            for (int c = 0; c < N_SRAM; c++) owner_q[c] <= OWN_FREE;
            gnt_q     <= '0;
            err_q     <= '0;
            rr_last_q <= 1'b1;
        end else begin
            err_q <= err_d;
            if (tie) rr_last_q <= ~rr_last_q;
            for (int r = 0; r < N_REQ; r++) begin
                case (state_q[r])
                    ST_IDLE: begin
                        if (req_valid[r] && req_mask[r] != '0) begin
                            mask_q[r]  <= req_mask[r];
                            state_q[r] <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (grant[r]) begin
                            state_q[r] <= ST_OWN;
                            gnt_q[r]   <= 1'b1;
                            for (int c = 0; c < N_SRAM; c++)
                                if (mask_q[r][c]) owner_q[c] <= owner_code(r);
                        end
                    end
                    ST_OWN, ST_DRAIN: begin
                        if (to_drain[r]) begin
                            state_q[r] <= ST_DRAIN;
                        end else if (leaving[r]) begin
                            state_q[r] <= ST_RELEASE;
                            gnt_q[r]   <= 1'b0;
                            for (int c = 0; c < N_SRAM; c++)
                                if (mask_q[r][c]) owner_q[c] <= OWN_RELEASING;
                        end
                    end
                    ST_RELEASE: begin
                        state_q[r] <= ST_IDLE;
                        for (int c = 0; c < N_SRAM; c++)
                            if (mask_q[r][c]) owner_q[c] <= OWN_FREE;
                    end
                    default: state_q[r] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_SRAM; c++) channel_owner[c] = owner_q[c];
    end

    assign gnt       = gnt_q;
    assign req_error = err_q;

endmodule

// File: doc/sram_channel_arbiter.md
Name: sram_channel_arbiter

Overview:
- Shares the four serial SRAM channels between two requesters: requester 0 is the host/Pi SPI bridge, requester 1 is the accelerator job engine, for example background subtraction.
- Each requester claims a channel mask. The whole mask is granted atomically, so a requester gets all the channels it asked for or none.
- While a grant is held, the owner's inst/address/byte_length/write_in drive those SRAM controllers, and mem_out/io_valid/rw_done are routed back to the owner only.
- The block sits between the job engines and the four SRAM controllers.

Parameters:
- N_SRAM, 4, number of SRAM channels (the mask width).
- N_REQ, 2, number of requesters (the behaviour below is written for 2).
- ADDR_W, 24, width of address and byte_length.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [0:1]x1  claim request, level; sampled only in IDLE.
- req_mask  in  [0:1]x4  channels claimed; sampled with req_valid.
- req_release  in  [0:1]x1  one-cycle pulse; releases all owned channels.
- gnt  out  [0:1]x1  high while the requester owns its mask.
- req_error  out  [0:1]x1  one-cycle error pulse.
- r_inst  in  [0:1][0:3]x8  requester-side inst per channel (0 NOP, 2 write, 3 read).
- r_address  in  [0:1][0:3]x24  requester-side address per channel.
- r_byte_length  in  [0:1][0:3]x24  requester-side byte_length per channel.
- r_write_in  in  [0:1][0:3]x1  requester-side serial write bit per channel.
- r_mem_out  out  [0:1][0:3]x1  routed serial read bit.
- r_io_valid  out  [0:1][0:3]x1  routed io_valid.
- r_rw_done  out  [0:1][0:3]x1  routed rw_done.
- inst  out  [0:3]x8  to SRAM controller.
- address  out  [0:3]x24  to SRAM controller.
- byte_length  out  [0:3]x24  to SRAM controller.
- write_in  out  [0:3]x1  to SRAM controller.
- mem_out  in  [0:3]x1  from SRAM controller.
- io_valid  in  [0:3]x1  from SRAM controller.
- rw_done  in  [0:3]x1  from SRAM controller.
- channel_owner  out  [0:3]x2  per channel: 00 free, 01 requester 0, 10 requester 1, 11 releasing.

Behaviour:
- Reset state: gnt=0, req_error=0, channel_owner=00, all SRAM-side outputs 0, all r_* outputs 0, rr_last=1 (requester 0 wins the first tie), all op_active=0.
- Reset mid-operation: ownership is dropped and inst is forced to 0 at the same edge. Pending SRAM transfers are abandoned; rw_done arriving afterwards is discarded.
- Per-requester FSM states are IDLE, WAIT, OWN, DRAIN and RELEASE.
- IDLE:
  - req_valid=1 with mask≠0 latches the mask and goes to WAIT.
  - mask=0 pulses req_error and stays in IDLE.
- WAIT: the grant is decided when every latched channel is free (channel_owner=00).
  - Both requesters grantable with overlapping masks: the winner is !rr_last, and rr_last updates to the winner.
  - Disjoint masks are both granted in the same cycle.
  - At the grant edge: go to OWN, gnt=1, channel_owner set.
  - Minimum latency: req_valid sampled at edge N puts the FSM in WAIT; gnt is high after edge N+1.
- OWN:
  - Owned channels pass the requester's inst/address/byte_length/write_in through combinationally.
  - mem_out/io_valid/rw_done are passed to the owner's r_* outputs; the non-owner sees 0.
- op_active per channel:
  - Set on any cycle with an owned, nonzero inst.
  - Cleared on rw_done for that channel.
  - Simultaneous set and clear: clear wins, then set applies next cycle if inst is still nonzero.
- req_release in OWN:
  - If no owned channel has op_active, go to RELEASE.
  - Otherwise go to DRAIN; gnt stays 1 and forwarding continues.
- DRAIN: once all owned op_active are 0, go to RELEASE.
- RELEASE (exactly 1 cycle):
  - gnt=0 and channel_owner=11.
  - Owned channels are forced to inst=0, address=0, byte_length=0, write_in=0.
  - Next edge: channel_owner=00 and FSM back to IDLE; the channel is grantable in that cycle.
- Errors:
  - Nonzero r_inst on a channel the requester does not own is ignored, never reaches the SRAM, and pulses req_error.
  - req_release outside OWN is ignored and pulses req_error.
- Unowned or free channels drive all-zero SRAM-side outputs.
- req_mask changes while in WAIT or OWN are ignored; the latched mask is authoritative.

Decomposition:
- Package sram_arb_pkg holds:
  - INST_NOP=0, INST_WRITE=2, INST_READ=3;
  - N_SRAM, N_REQ;
  - owner encoding typedef (FREE, REQ0, REQ1, RELEASING);
  - requester FSM state enum.
- Sub-module sram_channel_port, one instance per channel:
  - owner-based forward mux and return demux;
  - op_active tracker;
  - exports op_active and the illegal-inst flag to the top.

Test Plan:
- Single grant: req0 with mask 0011 → gnt[0]=1 two edges later; inst[0]=3 passes to channel 0; r_io_valid[1][0] stays 0.
- Tie: req0 mask 0110 and req1 mask 0100 in the same cycle after reset → gnt[0]=1, gnt[1]=0. req0 releases → gnt[1]=1 exactly 2 cycles after the release pulse (RELEASE cycle, then WAIT grant).
- Disjoint: req0 mask 0001 and req1 mask 1000 together → both gnt high in the same cycle; both channels forward independently.
- Drain: owner issues inst=2 on channel 2, then req_release before rw_done → gnt stays 1 until rw_done[2]. One RELEASE cycle follows with channel_owner[2]=11, then 00.
- Illegal/errors: req1 drives r_inst[1][0]=3 while req0 owns channel 0 → inst[0] follows req0 only and req_error[1] pulses. req_valid with mask 0000 → req_error pulses and there is no state change.
- Reset mid-transfer: reset during an active read → next edge gnt=0, all inst=0, channel_owner=00. A late rw_done is not forwarded.
